// File: rtl/rfblackwidow_mem_drain_pkg.sv
// Shared memory-request types, size/function codes and lane helpers
// for the BlackWidow memory queue drain.
package rfBlackWidowPkg;

    localparam logic [3:0] MR_LOAD  = 4'h0;
    localparam logic [3:0] MR_LOADZ = 4'h1;
    localparam logic [3:0] MR_STORE = 4'h2;

    localparam logic [2:0] SZ_BYTE  = 3'd0;
    localparam logic [2:0] SZ_WYDE  = 3'd1;
    localparam logic [2:0] SZ_TETRA = 3'd2;
    localparam logic [2:0] SZ_PENTA = 3'd3;
    localparam logic [2:0] SZ_OCTA  = 3'd4;
    localparam logic [2:0] SZ_DECI  = 3'd5;
    localparam logic [2:0] SZ_HEXI  = 3'd6;

    // adr is carried at 32 bits; the drain uses its low AWID bits.
    typedef struct packed {
        logic [3:0]   func;
        logic [2:0]   sz;
        logic [7:0]   tid;
        logic [31:0]  adr;
        logic [127:0] dat;
    } MemoryRequest;

    function automatic logic [15:0] fnSel(input logic [2:0] sz);
        unique case (sz)
            SZ_BYTE:  return 16'h0001;
            SZ_WYDE:  return 16'h0003;
            SZ_TETRA: return 16'h000F;
            SZ_PENTA: return 16'h001F;
            SZ_OCTA:  return 16'h00FF;
            SZ_DECI:  return 16'h03FF;
            SZ_HEXI:  return 16'hFFFF;
            default:  return 16'h0000;
        endcase
    endfunction

    function automatic logic [4:0] fnBytes(input logic [2:0] sz);
        unique case (sz)
            SZ_BYTE:  return 5'd1;
            SZ_WYDE:  return 5'd2;
            SZ_TETRA: return 5'd4;
            SZ_PENTA: return 5'd5;
            SZ_OCTA:  return 5'd8;
            SZ_DECI:  return 5'd10;
            SZ_HEXI:  return 5'd16;
            default:  return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/rfblackwidow_mem_drain_load_align.sv
// Right-aligns, masks and extends load data from the 256-bit assembly.
// Ports: i_asm assembly, i_ofs byte offset, i_sz size, i_func, o_dat.
module rfblackwidow_load_align
    import rfBlackWidowPkg::*;
(
    input  logic [255:0] i_asm,
    input  logic [3:0]   i_ofs,
    input  logic [2:0]   i_sz,
    input  logic [3:0]   i_func,
    output logic [127:0] o_dat
);

    logic [127:0] w_low;
    logic [127:0] w_bm;
    logic [15:0]  w_sel;
    logic [3:0]   w_last;
    logic         w_sign;

    assign w_low  = 128'(i_asm >> {i_ofs, 3'b000});
    assign w_sel  = fnSel(i_sz);
    assign w_last = 4'(fnBytes(i_sz) - 5'd1);
    // MSB of the top byte of the access
    assign w_sign = w_low[{w_last, 3'b111}];

    always_comb begin
        w_bm = '0;
        for (int i = 0; i < 16; i++)
            w_bm[i*8 +: 8] = {8{w_sel[i]}};
    end

    always_comb begin
        o_dat = '0;
        unique case (1'b1)
            (i_func == MR_LOAD):
                o_dat = (w_low & w_bm) | ({128{w_sign}} & ~w_bm);
            (i_func == MR_LOADZ):
                o_dat = w_low & w_bm;
            default:
                o_dat = '0;
        endcase
    end

endmodule

// File: rtl/rfblackwidow_mem_drain.sv
// Drains the memory queue head onto a 128-bit bus, splitting lane-crossing
// accesses. Ports: q_* queue head, *_o/*_i bus, resp_* response, busy.
module rfblackwidow_mem_drain
    import rfBlackWidowPkg::*;
#(
    parameter int AWID = 32,
    parameter int TMO  = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  MemoryRequest    q_o,
    input  logic            q_valid,
    output logic            q_rd,
    output logic            cyc_o,
    output logic            stb_o,
    output logic            we_o,
    output logic [15:0]     sel_o,
    output logic [AWID-1:0] adr_o,
    output logic [127:0]    dat_o,
    input  logic            ack_i,
    input  logic            err_i,
    input  logic [127:0]    dat_i,
    output logic            resp_valid,
    output logic [7:0]      resp_tid,
    output logic [127:0]    resp_dat,
    output logic            resp_err,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, BUS1, BUS2, DONE} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

    state_t          r_state;
    logic [3:0]      r_func;
    logic [2:0]      r_sz;
    logic [7:0]      r_tid;
    logic [3:0]      r_ofs;
    logic [15:0]     r_hi_sel;
    logic [127:0]    r_hi_dat;
    logic [7:0]      r_tmo;
    logic [255:0]    r_asm;
    logic            r_cyc;
    logic            r_we;
    logic [15:0]     r_sel;
    logic [AWID-1:0] r_adr;
    logic [127:0]    r_dat;
    logic            r_q_rd;
    logic            r_resp_valid;
    logic            r_resp_err;

    logic [31:0]     w_mask;
    logic [255:0]    w_wdat;
    logic            w_func_ok;
    logic            w_bus;
    logic            w_go2;
    logic            w_tmo_hit;
    logic            w_fin;
    logic            w_fin_err;
    logic            w_cap;
    logic [127:0]    w_aligned;

    assign w_mask = {16'h0, fnSel(q_o.sz)} << q_o.adr[3:0];
    assign w_wdat = {128'h0, q_o.dat} << {q_o.adr[3:0], 3'b000};
    assign w_func_ok = (q_o.func == MR_LOAD) || (q_o.func == MR_LOADZ)
                    || (q_o.func == MR_STORE);

    // err beats ack; the timeout only fires on a silent cycle
    assign w_bus     = (r_state == BUS1) || (r_state == BUS2);
    assign w_go2     = (r_state == BUS1) && ack_i && !err_i
                    && (r_hi_sel != 16'h0);
    assign w_tmo_hit = !ack_i && !err_i && (r_tmo == TMO_LAST);
    assign w_fin     = w_bus && (err_i || (ack_i && !w_go2) || w_tmo_hit);
    assign w_fin_err = err_i || w_tmo_hit;
    assign w_cap     = w_bus && ack_i && !err_i && (r_func != MR_STORE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_func       <= '0;
            r_sz         <= '0;
            r_tid        <= '0;
            r_ofs        <= '0;
            r_hi_sel     <= '0;
            r_hi_dat     <= '0;
            r_tmo        <= '0;
            r_asm        <= '0;
            r_cyc        <= 1'b0;
            r_we         <= 1'b0;
            r_sel        <= '0;
            r_adr        <= '0;
            r_dat        <= '0;
            r_q_rd       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
        end else begin
            r_q_rd       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            unique case (r_state)
                IDLE: if (q_valid) begin
                    r_func <= q_o.func;
                    r_sz   <= q_o.sz;
                    r_tid  <= q_o.tid;
                    r_ofs  <= q_o.adr[3:0];
                    r_asm  <= '0;
                    r_tmo  <= '0;
                    if (w_func_ok) begin
                        r_state  <= BUS1;
                        r_cyc    <= 1'b1;
                        r_we     <= (q_o.func == MR_STORE);
                        r_sel    <= w_mask[15:0];
                        r_adr    <= {q_o.adr[AWID-1:4], 4'h0};
                        r_dat    <= w_wdat[127:0];
                        r_hi_sel <= w_mask[31:16];
                        r_hi_dat <= w_wdat[255:128];
                    end else begin
                        r_state      <= DONE;
                        r_q_rd       <= 1'b1;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                    end
                end
                BUS1, BUS2: begin
                    if (w_cap) begin
                        if (r_state == BUS1)
                            r_asm[127:0] <= dat_i;
                        else
                            r_asm[255:128] <= dat_i;
                    end
                    if (w_fin) begin
                        r_state      <= DONE;
                        r_cyc        <= 1'b0;
                        r_we         <= 1'b0;
                        r_sel        <= '0;
                        r_adr        <= '0;
                        r_dat        <= '0;
                        r_q_rd       <= 1'b1;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= w_fin_err;
                    end else if (w_go2) begin
                        r_state <= BUS2;
                        r_sel   <= r_hi_sel;
                        r_adr   <= r_adr + AWID'(16);
                        r_dat   <= r_hi_dat;
                        r_tmo   <= '0;
                    end else begin
                        r_tmo <= r_tmo + 8'd1;
                    end
                end
                DONE: r_state <= IDLE;
            endcase
        end
    end

    rfblackwidow_load_align u_align (
        .i_asm  (r_asm),
        .i_ofs  (r_ofs),
        .i_sz   (r_sz),
        .i_func (r_func),
        .o_dat  (w_aligned)
    );

    assign q_rd       = r_q_rd;
    assign cyc_o      = r_cyc;
    assign stb_o      = r_cyc;
    assign we_o       = r_we;
    assign sel_o      = r_sel;
    assign adr_o      = r_adr;
    assign dat_o      = r_dat;
    assign resp_valid = r_resp_valid;
    assign resp_tid   = r_tid;
    assign resp_dat   = r_resp_valid ? w_aligned : 128'h0;
    assign resp_err   = r_resp_err;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_rfblackwidow_mem_drain.sv
// Bench for rfblackwidow_mem_drain: vector table with a response
// scoreboard, plus timeout, err+ack and reset-in-BUS2 sequences.
module tb_rfblackwidow_mem_drain;
    import rfBlackWidowPkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    MemoryRequest q_o;
    logic         q_valid = 1'b0;
    logic         q_rd;
    logic         cyc_o;
    logic         stb_o;
    logic         we_o;
    logic [15:0]  sel_o;
    logic [31:0]  adr_o;
    logic [127:0] dat_o;
    logic         ack_i = 1'b0;
    logic         err_i = 1'b0;
    logic [127:0] dat_i = '0;
    logic         resp_valid;
    logic [7:0]   resp_tid;
    logic [127:0] resp_dat;
    logic         resp_err;
    logic         busy;

    rfblackwidow_mem_drain #(.AWID(32), .TMO(255)) dut (
        .clk(clk), .rst(rst),
        .q_o(q_o), .q_valid(q_valid), .q_rd(q_rd),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
        .sel_o(sel_o), .adr_o(adr_o), .dat_o(dat_o),
        .ack_i(ack_i), .err_i(err_i), .dat_i(dat_i),
        .resp_valid(resp_valid), .resp_tid(resp_tid),
        .resp_dat(resp_dat), .resp_err(resp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int n_qrd = 0;

    always @(negedge clk) if (q_rd) n_qrd++;

    typedef struct {
        logic [3:0]   func;
        logic [2:0]   sz;
        logic [31:0]  adr;
        logic [127:0] wdat;
        logic [127:0] rlo;
        logic [127:0] rhi;
        int           nbus;
        logic [15:0]  sel1;
        logic [15:0]  sel2;
        logic [31:0]  adr1;
        logic [31:0]  adr2;
        logic [127:0] dat1;
        logic [127:0] dat2;
    } vec_t;

    typedef struct {
        logic [7:0]   tid;
        logic [127:0] dat;
        logic         err;
        bit           chk_dat;
    } exp_t;

    vec_t tv[8];
    exp_t sb[$];

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int nbytes(input logic [2:0] sz);
        case (sz)
            SZ_BYTE:  return 1;
            SZ_WYDE:  return 2;
            SZ_TETRA: return 4;
            SZ_PENTA: return 5;
            SZ_OCTA:  return 8;
            SZ_DECI:  return 10;
            SZ_HEXI:  return 16;
            default:  return 0;
        endcase
    endfunction

    // byte-by-byte picture of what a load should return
    function automatic logic [127:0] model(input logic [3:0] f,
        input logic [2:0] sz, input logic [3:0] ofs,
        input logic [127:0] lo, input logic [127:0] hi);
        logic [255:0] a;
        logic [127:0] r;
        int n;
        a = {hi, lo};
        r = '0;
        n = nbytes(sz);
        if (f != MR_LOAD && f != MR_LOADZ) return '0;
        for (int b = 0; b < n; b++)
            r[b*8 +: 8] = a[(int'(ofs) + b)*8 +: 8];
        if (f == MR_LOAD && n < 16 && r[n*8-1])
            for (int k = n*8; k < 128; k++) r[k] = 1'b1;
        return r;
    endfunction

    task automatic set_tv(input int i, input logic [3:0] f,
        input logic [2:0] sz, input logic [31:0] adr,
        input logic [127:0] wdat, input logic [127:0] rlo,
        input logic [127:0] rhi, input int nbus,
        input logic [15:0] s1, input logic [15:0] s2,
        input logic [31:0] a1, input logic [31:0] a2,
        input logic [127:0] d1, input logic [127:0] d2);
        tv[i].func = f;   tv[i].sz = sz;    tv[i].adr = adr;
        tv[i].wdat = wdat; tv[i].rlo = rlo; tv[i].rhi = rhi;
        tv[i].nbus = nbus; tv[i].sel1 = s1; tv[i].sel2 = s2;
        tv[i].adr1 = a1;  tv[i].adr2 = a2;
        tv[i].dat1 = d1;  tv[i].dat2 = d2;
    endtask

    task automatic check_resp();
        exp_t e;
        if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL sb_empty act=resp exp=none");
        end else begin
            e = sb.pop_front();
            chk("resp_tid", resp_tid, e.tid);
            chk("resp_err", resp_err, e.err);
            if (e.chk_dat) chk("resp_dat", resp_dat, e.dat);
        end
    endtask

    task automatic do_req(input int i, input bit noisy);
        MemoryRequest r;
        exp_t e;
        int q0, lat, nb, g;
        logic bad;
        r.func = tv[i].func; r.sz = tv[i].sz;
        r.tid = 8'h20 + 8'(i); r.adr = tv[i].adr;
        r.dat = tv[i].wdat;
        bad = !(r.func == MR_LOAD || r.func == MR_LOADZ
                || r.func == MR_STORE);
        e.tid = r.tid; e.err = bad; e.chk_dat = 1'b1;
        e.dat = model(r.func, r.sz, r.adr[3:0], tv[i].rlo, tv[i].rhi);
        sb.push_back(e);
        q0 = n_qrd; lat = 1; nb = 0; g = 0;
        q_o = r; q_valid = 1'b1;
        step(); lat++;
        if (noisy) begin
            q_o.tid = 8'hEE; q_o.adr = 32'hFFFF_FFF0;
            q_o.func = MR_STORE;
        end else q_valid = 1'b0;
        while (!resp_valid && g < 50) begin
            if (cyc_o) begin
                chk("stb", stb_o, 1'b1);
                chk("sel", sel_o, nb == 0 ? tv[i].sel1 : tv[i].sel2);
                chk("adr", adr_o, nb == 0 ? tv[i].adr1 : tv[i].adr2);
                chk("we", we_o, tv[i].func == MR_STORE);
                if (tv[i].func == MR_STORE)
                    chk("dat_o", dat_o,
                        nb == 0 ? tv[i].dat1 : tv[i].dat2);
                ack_i = 1'b1;
                dat_i = nb == 0 ? tv[i].rlo : tv[i].rhi;
                nb++;
            end
            step(); ack_i = 1'b0; lat++; g++;
        end
        chk("resp_valid", resp_valid, 1'b1);
        if (resp_valid) check_resp();
        else sb.delete();
        chk("q_rd", q_rd, 1'b1);
        chk("cyc_done", cyc_o, 1'b0);
        chk("latency", lat, tv[i].nbus + 2);
        chk("nbus", nb, tv[i].nbus);
        q_valid = 1'b0;
        step();
        chk("busy_idle", busy, 1'b0);
        chk("q_rd_pulse", q_rd, 1'b0);
        chk("rv_pulse", resp_valid, 1'b0);
        chk("q_rd_count", n_qrd - q0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1);
    end

    initial begin
        MemoryRequest r;
        exp_t e;
        int q0, ncyc, got;

        set_tv(0, MR_STORE, SZ_OCTA, 32'h100,
               128'h1122334455667788, '0, '0, 1,
               16'h00FF, 16'h0, 32'h100, 32'h0,
               128'h1122334455667788, '0);
        set_tv(1, MR_LOAD, SZ_DECI, 32'h10C, '0,
               128'h80112233_44556677_8899AABB_CCDDEEFF,
               128'h01020304_05060708_0909F1F2_F3F4F5FF, 2,
               16'hF000, 16'h003F, 32'h100, 32'h110, '0, '0);
        set_tv(2, MR_LOADZ, SZ_BYTE, 32'h203, '0,
               128'hEEEEEEEE_EEEEEEEE_EEEEEEEE_9A112233, '0, 1,
               16'h0008, 16'h0, 32'h200, 32'h0, '0, '0);
        set_tv(3, MR_LOAD, SZ_BYTE, 32'h203, '0,
               128'hEEEEEEEE_EEEEEEEE_EEEEEEEE_9A112233, '0, 1,
               16'h0008, 16'h0, 32'h200, 32'h0, '0, '0);
        set_tv(4, MR_LOAD, SZ_WYDE, 32'h00F, '0,
               128'h34CCCCCC_CCCCCCCC_CCCCCCCC_CCCCCCCC,
               128'hCCCCCCCC_CCCCCCCC_CCCCCCCC_CCCCCC12, 2,
               16'h8000, 16'h0001, 32'h0, 32'h10, '0, '0);
        set_tv(5, MR_STORE, SZ_TETRA, 32'h00E,
               128'hAABBCCDD, '0, '0, 2,
               16'hC000, 16'h0003, 32'h0, 32'h10,
               128'hCCDD0000_00000000_00000000_00000000,
               128'h0000AABB);
        set_tv(6, MR_LOADZ, SZ_HEXI, 32'h3F0, '0,
               128'h01234567_89ABCDEF_FEDCBA98_76543210, '0, 1,
               16'hFFFF, 16'h0, 32'h3F0, 32'h0, '0, '0);
        set_tv(7, 4'hF, SZ_OCTA, 32'h100, '0, '0, '0, 0,
               16'h0, 16'h0, 32'h0, 32'h0, '0, '0);

        q_o = '0;
        step(); step(); step();
        chk("rst_cyc", cyc_o, 1'b0);
        chk("rst_stb", stb_o, 1'b0);
        chk("rst_we", we_o, 1'b0);
        chk("rst_sel", sel_o, 16'h0);
        chk("rst_adr", adr_o, 32'h0);
        chk("rst_dat", dat_o, 128'h0);
        chk("rst_q_rd", q_rd, 1'b0);
        chk("rst_rv", resp_valid, 1'b0);
        chk("rst_tid", resp_tid, 8'h0);
        chk("rst_rdat", resp_dat, 128'h0);
        chk("rst_rerr", resp_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) do_req(i, i == 2);

        // silent bus: timeout after 255 bus clocks
        r = '0; r.func = MR_LOADZ; r.sz = SZ_OCTA;
        r.tid = 8'h77; r.adr = 32'h40;
        e.tid = 8'h77; e.dat = '0; e.err = 1'b1; e.chk_dat = 1'b0;
        sb.push_back(e);
        q0 = n_qrd; ncyc = 0; got = 0;
        q_o = r; q_valid = 1'b1;
        step(); q_valid = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (cyc_o) ncyc++;
            if (resp_valid) begin
                got++;
                check_resp();
            end
            step();
        end
        chk("tmo_cycles", ncyc, 255);
        chk("tmo_resp", got, 1);
        chk("tmo_q_rd", n_qrd - q0, 1);

        // err and ack together in BUS1 of a split deci load
        r = '0; r.func = MR_LOAD; r.sz = SZ_DECI;
        r.tid = 8'h55; r.adr = 32'h10C;
        e.tid = 8'h55; e.dat = '0; e.err = 1'b1; e.chk_dat = 1'b0;
        sb.push_back(e);
        q0 = n_qrd;
        q_o = r; q_valid = 1'b1;
        step(); q_valid = 1'b0;
        chk("ea_sel1", sel_o, 16'hF000);
        ack_i = 1'b1; err_i = 1'b1; dat_i = '1;
        step(); ack_i = 1'b0; err_i = 1'b0;
        chk("ea_cyc", cyc_o, 1'b0);
        chk("ea_rv", resp_valid, 1'b1);
        if (resp_valid) check_resp();
        else sb.delete();
        ncyc = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (cyc_o) ncyc++;
        end
        chk("ea_no_bus2", ncyc, 0);
        chk("ea_q_rd", n_qrd - q0, 1);

        // reset while in BUS2: bus drops, no pop
        r = '0; r.func = MR_LOAD; r.sz = SZ_DECI;
        r.tid = 8'h66; r.adr = 32'h10C;
        q0 = n_qrd;
        q_o = r; q_valid = 1'b1;
        step(); q_valid = 1'b0;
        ack_i = 1'b1; dat_i = tv[1].rlo;
        step(); ack_i = 1'b0;
        chk("r2_cyc_in", cyc_o, 1'b1);
        chk("r2_adr", adr_o, 32'h110);
        rst = 1'b1;
        step();
        chk("r2_cyc", cyc_o, 1'b0);
        chk("r2_stb", stb_o, 1'b0);
        chk("r2_busy", busy, 1'b0);
        chk("r2_rv", resp_valid, 1'b0);
        rst = 1'b0;
        step(); step();
        chk("r2_no_pop", n_qrd - q0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
